pipe_hold_stage: RTL
====================

// Module: pipe_hold_stage
// PURPOSE
//  Handshaked pipeline hold register: the read/drain side of the processor's enable-latched storage.
//  Captures a word from the upstream stage on valid&ready and holds it for the downstream consumer.
//  Two-entry skid design: in_ready is registered, so there is no combinational ready path across stages.
//  Sits between processor pipeline stages (e.g. decode->execute); supports flush on branch/exception.
// PARAMETERS
//  DATA_W   16  width of the held data word
//  CNT_W    16  stall-counter width (used only with PIPE_STALL_CNT_EN)
// PORTS
//  clk         in   1        single clock; all state updates on rising edge
//  rst_n       in   1        synchronous reset, active-low
//  in_valid    in   1        upstream word present
//  in_ready    out  1        stage can accept; registered
//  in_data     in   DATA_W   upstream word
//  out_valid   out  1        held word present
//  out_ready   in   1        downstream accepts
//  out_data    out  DATA_W   held word; registered (main entry)
//  flush       in   1        discard all held words
//  stall_cnt   out  CNT_W    stall cycles (only with PIPE_STALL_CNT_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0, stall_cnt=0.
//  Reset mid-transfer discards both entries; no word escapes after reset.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  States (2-bit): EMPTY (0 words), ONE (main full), TWO (main+skid full).
//   EMPTY: push -> main<=in_data, ONE.
//   ONE:   push&pop -> main<=in_data, stay ONE; push only -> skid<=in_data, TWO;
//          pop only -> EMPTY; neither -> hold.
//   TWO:   in_ready=0, so push is impossible; pop -> main<=skid, ONE; else hold.
//  out_valid = (state!=EMPTY); in_ready = (state!=TWO); both are registered, derived from next state.
//  Latency: word pushed at edge N appears on out_data/out_valid after edge N; min 1 cycle in->out.
//  Throughput: 1 word/cycle while out_ready=1; ordering strictly FIFO; no duplication or loss.
//  out_data is stable while out_valid=1 & out_ready=0; in_data is don't-care when in_valid=0.
//  flush=1: next state EMPTY, out_valid=0, in_ready=1; overrides push and pop in the same cycle
//   (simultaneous push is dropped); data registers are left unchanged (no clear needed).
//  rst_n has priority over flush.
//  in_valid while in_ready=0 has no effect; upstream must hold the word until in_ready=1.
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined: stall_cnt increments each cycle with out_valid=1 & out_ready=0;
//   saturates at all-ones (no wrap); cleared by reset and flush; flush cycle itself is not counted.
//  Undefined: port stall_cnt is absent; no counter logic.
// STRUCTURE
//  Shared package proc_pkg: PIPE_EMPTY/PIPE_ONE/PIPE_TWO state encodings (2'd0/1/2), default DATA_W.
//  One sub-module: sat_counter (CNT_W, sync active-low reset, clear, inc) for stall_cnt under the macro.
//  All other logic inline: state register, main/skid data registers, next-state always block.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clks with in_valid=1, in_data=16'hBEEF -> out_valid=0, in_ready=1, out_data=0.
//  2 Streaming: out_ready=1, push 16'h0001..16'h0008 on back-to-back clks -> same 8 words out in order,
//    1-cycle latency, in_ready stays 1.
//  3 Backpressure: out_ready=0, push 16'hA1, 16'hA2 -> state TWO, in_ready=0; a third word 16'hA3 is held
//    by the bench; raise out_ready -> A1, A2, A3 out in order, no loss.
//  4 Flush: state TWO (words 16'h11, 16'h22), assert flush with in_valid=1, in_data=16'h33 -> next clk
//    out_valid=0, in_ready=1; 16'h33 never appears at the output.
//  5 Reset mid-operation: state TWO, rst_n=0 for 1 clk -> EMPTY; the next push 16'h55 is the first output.
//  6 PIPE_STALL_CNT_EN with CNT_W=4: hold out_valid=1 with out_ready=0 for 20 clks -> stall_cnt=4'hF
//    (saturated); flush -> 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor pipeline definitions: hold-stage state encodings and default widths.
package proc_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipeState_e;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_CNT_W  = 16;

endpackage : proc_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_hold_stage.sv
// Two-entry skid hold register between pipeline stages, with registered ready and flush.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_hold_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  pipeState_e        stateQ, stateD;
  logic [DATA_W-1:0] mainQ, mainD;
  logic [DATA_W-1:0] skidQ, skidD;
  logic              outValidQ, inReadyQ;
  logic              push, pop;

  assign push = in_valid & inReadyQ;
  assign pop  = outValidQ & out_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    stateD = stateQ;
    mainD  = mainQ;
    skidD  = skidQ;
    if (flush) begin
      // Flush only empties the stage; stale data words are never observed again.
      stateD = PIPE_EMPTY;
    end else begin
      unique case (stateQ)
        PIPE_EMPTY: begin
          if (push) begin
            mainD  = in_data;
            stateD = PIPE_ONE;
          end
        end
        PIPE_ONE: begin
          unique case ({push, pop})
            2'b11: mainD = in_data;
            2'b10: begin
              skidD  = in_data;
              stateD = PIPE_TWO;
            end
            2'b01: stateD = PIPE_EMPTY;
            default: ;
          endcase
        end
        PIPE_TWO: begin
          if (pop) begin
            mainD  = skidQ;
            stateD = PIPE_ONE;
          end
        end
        default: stateD = PIPE_EMPTY;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= PIPE_EMPTY;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      // NOTE: data registers are reset too so out_data reads a known zero after reset.
      mainQ     <= '0;
      skidQ     <= '0;
    end else begin
      stateQ    <= stateD;
      outValidQ <= (stateD != PIPE_EMPTY);
      inReadyQ  <= (stateD != PIPE_TWO);
      mainQ     <= mainD;
      skidQ     <= skidD;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign out_data  = mainQ;

`ifdef PIPE_STALL_CNT_EN
  // Clear wins over increment, so the flush cycle itself is never counted.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .inc   (outValidQ & ~out_ready),
    .count (stall_cnt)
  );
`endif

endmodule : pipe_hold_stage
